rc_lfsr_rev_gen: RTL and testbench

Sequential round-constant generator for the Shadow-512 datapath. It emits a programmable-length sequence of 32-bit LFSR constants, either in forward order or in reverse order. Reverse order uses the exact inverse of the forward step and serves the inverse permutation. It sits beside the round controller and delivers one constant per accepted valid/ready handshake.

---
 rtl/rc_lfsr_rev_gen.sv | 125 ++++++++++++
 tb/tb_rc_lfsr_rev_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_lfsr_rev_gen.sv
// Round-constant generator: emits NSTEPS LFSR constants per sequence, forward or reversed.
// Reverse mode first winds the register to c_{NSTEPS-1}, then walks back with the inverse step.
module rc_lfsr_rev_gen #(
  parameter logic [31:0] POLY   = 32'hc5,
  parameter logic [31:0] SEED   = 32'h0000_0001,
  parameter int unsigned NSTEPS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rev,
  input  logic        rc_ready,
  output logic        rc_valid,
  output logic [31:0] rc,
  output logic        rc_last,
  output logic        busy
);

  localparam int unsigned   CW      = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(NSTEPS - 1);

  typedef enum logic [1:0] {StIdle, StWind, StEmit} state_e;

  function automatic logic [31:0] fwd_step(input logic [31:0] x);
    return (x << 1) ^ (x[31] ? POLY : 32'h0);
  endfunction

  // Exact inverse of fwd_step; relies on POLY[0] = 1 to recover the shifted-out bit.
  function automatic logic [31:0] inv_step(input logic [31:0] y);
    return ((y ^ (y[0] ? POLY : 32'h0)) >> 1) | {y[0], 31'h0};
  endfunction

  state_e        state_q, state_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rev_q, rev_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    rev_d   = rev_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          lfsr_d = SEED;
          rev_d  = rev;
          busy_d = 1'b1;
          if (rev && (LastCnt != '0)) begin
            // cnt doubles as the wind-down counter before it counts emitted constants
            cnt_d   = LastCnt;
            state_d = StWind;
          end else begin
            cnt_d   = '0;
            state_d = StEmit;
            valid_d = 1'b1;
            last_d  = (LastCnt == '0);
          end
        end
      end
      StWind: begin
        lfsr_d = fwd_step(lfsr_q);
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StEmit;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      StEmit: begin
        if (rc_ready) begin
          if (last_q) begin
            state_d = StIdle;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            lfsr_d = rev_q ? inv_step(lfsr_q) : fwd_step(lfsr_q);
            cnt_d  = cnt_q + CW'(1);
            last_d = ((cnt_q + CW'(1)) == LastCnt);
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      rev_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      rev_q   <= rev_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign rc_valid = valid_q;
  assign rc       = lfsr_q;
  assign rc_last  = last_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rc_lfsr_rev_gen.sv
// Directed bench for rc_lfsr_rev_gen across several SEED/NSTEPS instances sharing one input set.
module tb_rc_lfsr_rev_gen;

  localparam logic [31:0] Poly = 32'hc5;

  logic clk = 1'b0;
  logic rst, start, rev, rc_ready;
  logic [31:0] rc_w [5];
  logic        valid_w [5];
  logic        last_w [5];
  logic        busy_w [5];

  int sel;
  logic [31:0] o_rc;
  logic o_valid, o_last, o_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap [40];
  logic [31:0] fv [40];
  int got;

  always #5 clk = ~clk;

  always_comb begin
    o_rc    = rc_w[sel];
    o_valid = valid_w[sel];
    o_last  = last_w[sel];
    o_busy  = busy_w[sel];
  end

  rc_lfsr_rev_gen #(.POLY(Poly), .SEED(32'h1), .NSTEPS(4)) u_d0 (
    .clk(clk), .rst(rst), .start(start), .rev(rev), .rc_ready(rc_ready),
    .rc_valid(valid_w[0]), .rc(rc_w[0]), .rc_last(last_w[0]), .busy(busy_w[0]));
  rc_lfsr_rev_gen #(.POLY(Poly), .SEED(32'h8000_0000), .NSTEPS(2)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .rev(rev), .rc_ready(rc_ready),
    .rc_valid(valid_w[1]), .rc(rc_w[1]), .rc_last(last_w[1]), .busy(busy_w[1]));
  rc_lfsr_rev_gen #(.POLY(Poly), .SEED(32'h8000_0000), .NSTEPS(1)) u_d2 (
    .clk(clk), .rst(rst), .start(start), .rev(rev), .rc_ready(rc_ready),
    .rc_valid(valid_w[2]), .rc(rc_w[2]), .rc_last(last_w[2]), .busy(busy_w[2]));
  rc_lfsr_rev_gen #(.POLY(Poly), .SEED(32'h1), .NSTEPS(12)) u_d3 (
    .clk(clk), .rst(rst), .start(start), .rev(rev), .rc_ready(rc_ready),
    .rc_valid(valid_w[3]), .rc(rc_w[3]), .rc_last(last_w[3]), .busy(busy_w[3]));
  rc_lfsr_rev_gen #(.POLY(Poly), .SEED(32'h9e37_79b9), .NSTEPS(40)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .rev(rev), .rc_ready(rc_ready),
    .rc_valid(valid_w[4]), .rc(rc_w[4]), .rc_last(last_w[4]), .busy(busy_w[4]));

  function automatic logic [31:0] model_f(input logic [31:0] x);
    return (x << 1) ^ (x[31] ? Poly : 32'h0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    rc_ready = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_last", 32'(o_last), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_rc", o_rc, 32'h0);
  endtask

  task automatic kick(input logic r);
    start = 1'b1;
    rev = r;
    step();
    start = 1'b0;
  endtask

  // Full reverse sequence on the SEED=1, NSTEPS=12 instance.
  task automatic run_rev12();
    rc_ready = 1'b1;
    kick(1'b1);
    for (int i = 0; i < 11; i++) begin
      chk("r12_wind_valid", 32'(o_valid), 32'h0);
      chk("r12_wind_busy", 32'(o_busy), 32'h1);
      step();
    end
    for (int i = 0; i < 12; i++) begin
      chk("r12_valid", 32'(o_valid), 32'h1);
      chk("r12_rc", o_rc, 32'h1 << (11 - i));
      chk("r12_last", 32'(o_last), 32'(i == 11));
      step();
    end
    chk("r12_done_busy", 32'(o_busy), 32'h0);
  endtask

  // Accept n constants under random backpressure, within a cycle budget.
  task automatic collect(input int n);
    int cycles = 0;
    got = 0;
    while (got < n && cycles < 500) begin
      rc_ready = 1'($urandom_range(0, 1));
      if (o_valid && rc_ready) begin
        cap[got] = o_rc;
        got++;
      end
      step();
      cycles++;
    end
    chk("collect_count", 32'(got), 32'(n));
  endtask

  initial begin
    logic [31:0] x;
    int acc;
    sel = 0;
    rst = 1'b0;
    start = 1'b0;
    rev = 1'b0;
    rc_ready = 1'b0;

    // Forward, SEED=1, NSTEPS=4
    do_reset();
    rc_ready = 1'b1;
    kick(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("f4_valid", 32'(o_valid), 32'h1);
      chk("f4_busy", 32'(o_busy), 32'h1);
      chk("f4_rc", o_rc, 32'h1 << i);
      chk("f4_last", 32'(o_last), 32'(i == 3));
      step();
    end
    chk("f4_done_busy", 32'(o_busy), 32'h0);
    chk("f4_done_valid", 32'(o_valid), 32'h0);

    // Reverse, SEED=1, NSTEPS=4
    do_reset();
    rc_ready = 1'b1;
    kick(1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("r4_wind_valid", 32'(o_valid), 32'h0);
      chk("r4_wind_busy", 32'(o_busy), 32'h1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk("r4_valid", 32'(o_valid), 32'h1);
      chk("r4_rc", o_rc, 32'h8 >> i);
      chk("r4_last", 32'(o_last), 32'(i == 3));
      step();
    end
    chk("r4_done_busy", 32'(o_busy), 32'h0);

    // Back-to-back: start in the cycle busy falls is accepted
    kick(1'b0);
    chk("b2b_valid", 32'(o_valid), 32'h1);
    chk("b2b_rc", o_rc, 32'h1);

    // Feedback wrap, SEED=0x80000000, NSTEPS=2
    sel = 1;
    do_reset();
    rc_ready = 1'b1;
    kick(1'b0);
    chk("w2f_rc0", o_rc, 32'h8000_0000);
    step();
    chk("w2f_rc1", o_rc, 32'h0000_00c5);
    chk("w2f_last", 32'(o_last), 32'h1);
    step();
    kick(1'b1);
    chk("w2r_wind_valid", 32'(o_valid), 32'h0);
    step();
    chk("w2r_rc0", o_rc, 32'h0000_00c5);
    chk("w2r_last0", 32'(o_last), 32'h0);
    step();
    chk("w2r_rc1", o_rc, 32'h8000_0000);
    chk("w2r_last1", 32'(o_last), 32'h1);
    step();
    chk("w2r_done_busy", 32'(o_busy), 32'h0);

    // NSTEPS=1 reverse: no wind phase
    sel = 2;
    do_reset();
    rc_ready = 1'b1;
    kick(1'b1);
    chk("n1_valid", 32'(o_valid), 32'h1);
    chk("n1_rc", o_rc, 32'h8000_0000);
    chk("n1_last", 32'(o_last), 32'h1);
    step();
    chk("n1_done_busy", 32'(o_busy), 32'h0);

    // Backpressure with ignored start pulses (rev=1 must not take effect)
    sel = 0;
    do_reset();
    kick(1'b0);
    acc = 0;
    for (int j = 0; j < 10; j++) begin
      rc_ready = (j % 3 == 0);
      start = (j % 3 != 0);
      rev = 1'b1;
      chk("bp_valid", 32'(o_valid), 32'h1);
      chk("bp_rc", o_rc, 32'h1 << ((j + 2) / 3));
      chk("bp_last", 32'(o_last), 32'(((j + 2) / 3) == 3));
      if (o_valid && rc_ready) acc++;
      step();
    end
    start = 1'b0;
    chk("bp_accepted", 32'(acc), 32'h4);
    chk("bp_done_busy", 32'(o_busy), 32'h0);

    // Reset during WIND cycle 5, then full reverse run
    sel = 3;
    do_reset();
    rc_ready = 1'b1;
    kick(1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("mw_in_wind", 32'(o_busy), 32'h1);
    do_reset();
    run_rev12();

    // Reset during EMIT after 3 handshakes, with a handshake pending
    kick(1'b1);
    for (int i = 0; i < 11; i++) step();
    rc_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("me_rc_before", o_rc, 32'h100);
    do_reset();
    run_rev12();

    // Long sequence under random backpressure: forward vs model, reverse vs forward
    sel = 4;
    do_reset();
    kick(1'b0);
    collect(40);
    x = 32'h9e37_79b9;
    for (int i = 0; i < 40; i++) begin
      fv[i] = cap[i];
      chk("rand_fwd", cap[i], x);
      x = model_f(x);
    end
    do_reset();
    kick(1'b1);
    collect(40);
    for (int i = 0; i < 40; i++) chk("rand_rev", cap[i], fv[39 - i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
